// File: rtl/apb_master_bridge_if.sv
// Request-side and APB-side signals of the APB master bridge.
// The bridge connects through "master"; the system master and completer model connect through "slave".
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int COMP       = 3
);
  logic                  MTRANS;
  logic                  MWRITE;
  logic [COMP-1:0]       MSELx;
  logic [ADDR_WIDTH-1:0] MADDR;
  logic [DATA_WIDTH-1:0] MWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic [COMP-1:0]       PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] MRDATA;

  modport master (
    input  MTRANS, MWRITE, MSELx, MADDR, MWDATA, PREADY, PRDATA,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA, MRDATA
  );

  modport slave (
    output MTRANS, MWRITE, MSELx, MADDR, MWDATA, PREADY, PRDATA,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, MRDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Turns single-cycle master requests into APB SETUP/ACCESS transfers and returns read data.
//
// state  | meaning
// IDLE   | no transfer; PSELx/PENABLE low, address/data hold last values
// SETUP  | one cycle with PSELx asserted, PENABLE low
// ACCESS | PENABLE high; held until PREADY, may chain directly into the next SETUP
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int COMP       = 3
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_master_bridge_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state;

  logic                  req_valid;
  logic                  accept;
  logic [COMP-1:0]       req_sel;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  assign req_sel   = bus.MSELx;
  assign req_addr  = bus.MADDR;
  assign req_wdata = bus.MWDATA;

  // A request with no completer selected is dropped, never queued.
  assign req_valid = bus.MTRANS && (req_sel != '0);
  assign accept    = req_valid &&
                     ((state == IDLE) || ((state == ACCESS) && bus.PREADY));

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state       <= IDLE;
      bus.PSELx   <= '0;
      bus.PENABLE <= 1'b0;
      bus.PWRITE  <= 1'b0;
      bus.PADDR   <= '0;
      bus.PWDATA  <= '0;
      bus.MRDATA  <= '0;
    end else begin
      // The APB output registers double as the captured request copy.
      if (accept) begin
        bus.PSELx  <= req_sel;
        bus.PWRITE <= bus.MWRITE;
        bus.PADDR  <= req_addr;
        bus.PWDATA <= req_wdata;
      end

      case (state)
        IDLE: begin
          bus.PENABLE <= 1'b0;
          if (accept) begin
            state <= SETUP;
          end else begin
            bus.PSELx <= '0;
          end
        end

        SETUP: begin
          bus.PENABLE <= 1'b1;
          state       <= ACCESS;
        end

        ACCESS: begin
          if (bus.PREADY) begin
            if (!bus.PWRITE) begin
              bus.MRDATA <= bus.PRDATA;
            end
            bus.PENABLE <= 1'b0;
            if (accept) begin
              state <= SETUP;
            end else begin
              state     <= IDLE;
              bus.PSELx <= '0;
            end
          end
        end

        default: begin
          state       <= IDLE;
          bus.PSELx   <= '0;
          bus.PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: stimulus and checks at the falling edge of PCLK.
module tb_apb_master_bridge;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int NC = 3;

  logic PCLK;
  logic PRESETn;

  int vectors;
  int miscompares;

  apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COMP(NC)) bus ();

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COMP(NC)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic check_bus(input string tag, input logic [NC-1:0] sel, input logic en,
                           input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    check({tag, ".psel"},    64'(bus.PSELx),   64'(sel));
    check({tag, ".penable"}, 64'(bus.PENABLE), 64'(en));
    check({tag, ".pwrite"},  64'(bus.PWRITE),  64'(wr));
    check({tag, ".paddr"},   64'(bus.PADDR),   64'(addr));
    check({tag, ".pwdata"},  64'(bus.PWDATA),  64'(wd));
  endtask

  task automatic cyc();
    @(negedge PCLK);
  endtask

  task automatic request(input logic wr, input logic [NC-1:0] sel,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bus.MTRANS = 1'b1;
    bus.MWRITE = wr;
    bus.MSELx  = sel;
    bus.MADDR  = addr;
    bus.MWDATA = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    PRESETn     = 1'b0;
    bus.MTRANS  = 1'b0;
    bus.MWRITE  = 1'b0;
    bus.MSELx   = '0;
    bus.MADDR   = '0;
    bus.MWDATA  = '0;
    bus.PREADY  = 1'b0;
    bus.PRDATA  = '0;

    cyc(); cyc();
    check_bus("por", 3'b000, 1'b0, 1'b0, 7'h00, 32'h0);
    check("por.mrdata", 64'(bus.MRDATA), 64'h0);
    PRESETn = 1'b1;
    cyc();

    // write, zero wait states
    request(1'b1, 3'b010, 7'h15, 32'hDEADBEEF);
    bus.PREADY = 1'b1;
    cyc();
    bus.MTRANS = 1'b0;
    check_bus("wr0.setup", 3'b010, 1'b0, 1'b1, 7'h15, 32'hDEADBEEF);
    cyc();
    check_bus("wr0.access", 3'b010, 1'b1, 1'b1, 7'h15, 32'hDEADBEEF);
    cyc();
    check_bus("wr0.idle", 3'b000, 1'b0, 1'b1, 7'h15, 32'hDEADBEEF);
    check("wr0.mrdata", 64'(bus.MRDATA), 64'h0);

    // read, five wait states
    request(1'b0, 3'b100, 7'h2A, 32'h0);
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'hFFFFFFFF;
    cyc();
    bus.MTRANS = 1'b0;
    check_bus("rd5.setup", 3'b100, 1'b0, 1'b0, 7'h2A, 32'h0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check_bus($sformatf("rd5.access%0d", i), 3'b100, 1'b1, 1'b0, 7'h2A, 32'h0);
      check($sformatf("rd5.mrdata_wait%0d", i), 64'(bus.MRDATA), 64'h0);
      bus.PREADY = (i == 5);
      bus.PRDATA = (i == 5) ? 32'h12345678 : 32'hFFFFFFFF;
    end
    cyc();
    bus.PREADY = 1'b0;
    check_bus("rd5.idle", 3'b000, 1'b0, 1'b0, 7'h2A, 32'h0);
    check("rd5.mrdata", 64'(bus.MRDATA), 64'h12345678);

    // three-wait write while request inputs toggle
    request(1'b1, 3'b001, 7'h33, 32'hA5A50F0F);
    cyc();
    bus.MTRANS = 1'b0;
    check_bus("tog.setup", 3'b001, 1'b0, 1'b1, 7'h33, 32'hA5A50F0F);
    for (int i = 0; i < 4; i++) begin
      bus.MWRITE = ~bus.MWRITE;
      bus.MADDR  = ~bus.MADDR;
      bus.MWDATA = ~bus.MWDATA;
      bus.MSELx  = (i % 2 == 0) ? 3'b110 : 3'b100;
      cyc();
      check_bus($sformatf("tog.access%0d", i), 3'b001, 1'b1, 1'b1, 7'h33, 32'hA5A50F0F);
      bus.PREADY = (i == 3);
    end
    cyc();
    bus.PREADY = 1'b0;
    check_bus("tog.idle", 3'b000, 1'b0, 1'b1, 7'h33, 32'hA5A50F0F);
    check("tog.mrdata", 64'(bus.MRDATA), 64'h12345678);

    // back-to-back: write chained directly into a read
    request(1'b1, 3'b010, 7'h40, 32'h11112222);
    cyc();
    bus.MTRANS = 1'b0;
    check_bus("b2b.wsetup", 3'b010, 1'b0, 1'b1, 7'h40, 32'h11112222);
    cyc();
    check_bus("b2b.waccess", 3'b010, 1'b1, 1'b1, 7'h40, 32'h11112222);
    request(1'b0, 3'b001, 7'h01, 32'h0);
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'hCAFEF00D;
    cyc();
    bus.MTRANS = 1'b0;
    check_bus("b2b.rsetup", 3'b001, 1'b0, 1'b0, 7'h01, 32'h0);
    check("b2b.mrdata_w", 64'(bus.MRDATA), 64'h12345678);
    cyc();
    check_bus("b2b.raccess", 3'b001, 1'b1, 1'b0, 7'h01, 32'h0);
    bus.PRDATA = 32'h0BADC0DE;
    cyc();
    bus.PREADY = 1'b0;
    check_bus("b2b.idle", 3'b000, 1'b0, 1'b0, 7'h01, 32'h0);
    check("b2b.mrdata_r", 64'(bus.MRDATA), 64'h0BADC0DE);

    // ignored requests: no select in IDLE, MTRANS in SETUP and in stalled ACCESS
    request(1'b1, 3'b000, 7'h7F, 32'hFFFF0000);
    cyc();
    check_bus("ign.nosel", 3'b000, 1'b0, 1'b0, 7'h01, 32'h0);
    request(1'b1, 3'b100, 7'h0A, 32'h5555AAAA);
    cyc();
    check_bus("ign.setup", 3'b100, 1'b0, 1'b1, 7'h0A, 32'h5555AAAA);
    request(1'b0, 3'b001, 7'h7E, 32'h0);
    bus.PREADY = 1'b1;
    cyc();
    check_bus("ign.access", 3'b100, 1'b1, 1'b1, 7'h0A, 32'h5555AAAA);
    bus.PREADY = 1'b0;
    cyc();
    check_bus("ign.stall", 3'b100, 1'b1, 1'b1, 7'h0A, 32'h5555AAAA);
    bus.MTRANS = 1'b0;
    bus.PREADY = 1'b1;
    cyc();
    bus.PREADY = 1'b0;
    check_bus("ign.idle", 3'b000, 1'b0, 1'b1, 7'h0A, 32'h5555AAAA);
    check("ign.mrdata", 64'(bus.MRDATA), 64'h0BADC0DE);

    // reset in the middle of ACCESS
    request(1'b0, 3'b001, 7'h11, 32'h0);
    cyc();
    bus.MTRANS = 1'b0;
    cyc();
    check_bus("rst.access", 3'b001, 1'b1, 1'b0, 7'h11, 32'h0);
    PRESETn    = 1'b0;
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'hFFFF0000;
    cyc(); cyc();
    check_bus("rst.held", 3'b000, 1'b0, 1'b0, 7'h00, 32'h0);
    check("rst.mrdata", 64'(bus.MRDATA), 64'h0);
    PRESETn = 1'b1;
    cyc(); cyc();
    check_bus("rst.after", 3'b000, 1'b0, 1'b0, 7'h00, 32'h0);
    check("rst.mrdata_after", 64'(bus.MRDATA), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
